// File: rtl/c5_fetch_unit_pkg.sv
// rtl/c5_fetch_unit_pkg.sv - shared constants and types for the C5 fetch stage.
package c5_fetch_unit_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t NOP_INSTR_DEF    = 32'h0000_0013;
  localparam word_t RESET_VECTOR_DEF = 32'h0000_0000;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

  function automatic word_t align_word(input word_t addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/c5_fetch_unit_if.sv
// rtl/c5_fetch_unit_if.sv - instruction-memory port plus decode-side controls of the fetch stage.
interface c5_fetch_unit_if;
  import c5_fetch_unit_pkg::*;

  word_t O_adr;
  logic  O_stb;
  word_t I_instr;
  logic  I_stall_instr;
  logic  I_stall;
  word_t I_pc_branch;
  logic  I_pc_src;
  word_t O_instr;
  word_t O_pc_plus_4;

  modport master (
    output O_adr, O_stb, O_instr, O_pc_plus_4,
    input  I_instr, I_stall_instr, I_stall, I_pc_branch, I_pc_src
  );

  modport slave (
    input  O_adr, O_stb, O_instr, O_pc_plus_4,
    output I_instr, I_stall_instr, I_stall, I_pc_branch, I_pc_src
  );
endinterface

// File: rtl/c5_fetch_unit_skid.sv
// rtl/c5_fetch_unit_skid.sv - one-entry holding buffer for a response that lands during a stall.
module c5_fetch_unit_skid
  import c5_fetch_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         clear_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q, valid_d;
  fetch_entry_t entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      entry_d = entry_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/c5_fetch_unit.sv
// rtl/c5_fetch_unit.sv - C5 instruction fetch: PC, single-outstanding imem port, F/D register.
module c5_fetch_unit
  import c5_fetch_unit_pkg::*;
#(
  parameter word_t RESET_VECTOR = RESET_VECTOR_DEF,
  parameter word_t NOP_INSTR    = NOP_INSTR_DEF
) (
  input  logic             I_clk,
  input  logic             I_rst,
  c5_fetch_unit_if.master  bus
);

  logic         issue;
  word_t        pc_q, pc_d;
  logic         resp_valid_q, resp_valid_d;
  word_t        resp_pc_q, resp_pc_d;
  word_t        instr_q, instr_d;
  word_t        pc4_q, pc4_d;
  logic         skid_load, skid_clear, skid_valid;
  fetch_entry_t skid_entry;

  assign issue = I_rst & ~bus.I_stall_instr & ~bus.I_stall & ~bus.I_pc_src;

  always_comb begin
    pc_d = pc_q;
    if (bus.I_pc_src) begin
      pc_d = align_word(bus.I_pc_branch);
    end else if (issue) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // A flush never issues, so this also drops the wrong-path response.
  assign resp_valid_d = issue;
  assign resp_pc_d    = issue ? pc_q : resp_pc_q;

  assign skid_load  = resp_valid_q & bus.I_stall & ~bus.I_pc_src;
  assign skid_clear = bus.I_pc_src | (~bus.I_stall & skid_valid);

  c5_fetch_unit_skid u_skid (
    .clk_i   (I_clk),
    .rst_ni  (I_rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .entry_i ('{instr: bus.I_instr, pc: resp_pc_q}),
    .valid_o (skid_valid),
    .entry_o (skid_entry)
  );

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (bus.I_pc_src) begin
      instr_d = NOP_INSTR;
    end else if (bus.I_stall) begin
      instr_d = instr_q;
    end else if (skid_valid) begin
      instr_d = skid_entry.instr;
      pc4_d   = skid_entry.pc + 32'd4;
    end else if (resp_valid_q) begin
      instr_d = bus.I_instr;
      pc4_d   = resp_pc_q + 32'd4;
    end else begin
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      pc_q         <= RESET_VECTOR;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= RESET_VECTOR;
      instr_q      <= NOP_INSTR;
      pc4_q        <= RESET_VECTOR;
    end else begin
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
    end
  end

  assign bus.O_adr       = pc_q;
  assign bus.O_stb       = I_rst;
  assign bus.O_instr     = instr_q;
  assign bus.O_pc_plus_4 = pc4_q;

endmodule

// File: tb/tb_c5_fetch_unit.sv
// tb/tb_c5_fetch_unit.sv - self-checking bench for c5_fetch_unit against a queue-based fetch model.
module tb_c5_fetch_unit;
  import c5_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  c5_fetch_unit_if bus ();

  c5_fetch_unit dut (
    .I_clk (clk),
    .I_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE000_0000 ^ a;
  endfunction

  // Model: PC, at most one accepted request in flight, and a queue of
  // delivered-but-not-yet-consumed responses.
  logic [31:0] m_pc, m_out, m_pc4;
  logic        m_infl;
  logic [31:0] m_infl_addr;
  logic [31:0] m_ready[$];
  bit          chk_en = 1'b0;

  logic        mem_pend;
  logic [31:0] mem_addr;

  task automatic model_reset();
    m_pc   = RESET_VECTOR_DEF;
    m_out  = NOP_INSTR_DEF;
    m_pc4  = RESET_VECTOR_DEF;
    m_infl = 1'b0;
    m_ready.delete();
    mem_pend = 1'b0;
    mem_addr = '0;
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("O_adr", bus.O_adr, m_pc);
      check("O_instr", bus.O_instr, m_out);
      check("O_pc_plus_4", bus.O_pc_plus_4, m_pc4);
      check("O_stb", {31'b0, bus.O_stb}, {31'b0, rst_n});
    end
  end

  task automatic step(input logic st, input logic sti, input logic ps, input logic [31:0] br);
    logic        acc;
    logic [31:0] a_now;
    logic [31:0] a;
    bus.I_stall       = st;
    bus.I_stall_instr = sti;
    bus.I_pc_src      = ps;
    bus.I_pc_branch   = br;
    bus.I_instr       = mem_pend ? mem_word(mem_addr) : 32'hBAD0_BAD0;
    a_now = bus.O_adr;
    acc   = rst_n & !st & !sti & !ps;
    if (ps) begin
      m_ready.delete();
      m_out  = NOP_INSTR_DEF;
      m_pc   = {br[31:2], 2'b00};
      m_infl = 1'b0;
    end else begin
      if (m_infl) m_ready.push_back(m_infl_addr);
      if (!st) begin
        if (m_ready.size() > 0) begin
          a     = m_ready.pop_front();
          m_out = mem_word(a);
          m_pc4 = a + 32'd4;
        end else begin
          m_out = NOP_INSTR_DEF;
        end
      end
      if (!st && !sti) begin
        m_infl      = 1'b1;
        m_infl_addr = m_pc;
        m_pc        = m_pc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    @(posedge clk);
    mem_pend = acc;
    mem_addr = a_now;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    bus.I_stall = 1'b0; bus.I_stall_instr = 1'b0; bus.I_pc_src = 1'b0;
    bus.I_pc_branch = '0; bus.I_instr = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("reset_adr", bus.O_adr, 32'h0);
    check("reset_instr", bus.O_instr, 32'h0000_0013);
    check("reset_pc4", bus.O_pc_plus_4, 32'h0);
    check("reset_stb", {31'b0, bus.O_stb}, 32'h0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("first_out_nop", bus.O_instr, 32'h0000_0013);
    check("first_adr", bus.O_adr, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("first_instr", bus.O_instr, 32'hE000_0000);
    check("first_pc4", bus.O_pc_plus_4, 32'h4);
    run(2);
    check("adr_at_10", bus.O_adr, 32'h10);

    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("imem_stall_hold", bus.O_adr, 32'h10);
    run(2);
    check("imem_stall_instr", bus.O_instr, 32'hE000_0010);
    check("imem_stall_pc4", bus.O_pc_plus_4, 32'h14);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("skid_instr", bus.O_instr, 32'hE000_0014);
    check("skid_pc4", bus.O_pc_plus_4, 32'h18);
    run(2);
    check("after_skid", bus.O_instr, 32'hE000_001C);

    step(1'b0, 1'b0, 1'b1, 32'h203);
    check("branch_adr", bus.O_adr, 32'h200);
    check("branch_flush_nop", bus.O_instr, 32'h0000_0013);
    run(1);
    check("branch_nop2", bus.O_instr, 32'h0000_0013);
    run(1);
    check("branch_instr", bus.O_instr, 32'hE000_0200);
    check("branch_pc4", bus.O_pc_plus_4, 32'h204);

    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h300);
    check("flush_stall_nop", bus.O_instr, 32'h0000_0013);
    run(1);
    check("flush_no_stale", bus.O_instr, 32'h0000_0013);
    run(1);
    check("flush_stall_instr", bus.O_instr, 32'hE000_0300);

    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    run(2);
    check("wrap_adr", bus.O_adr, 32'h0);
    run(1);
    check("wrap_pc4", bus.O_pc_plus_4, 32'h0);
    run(1);

    #2 rst_n = 1'b0;
    #1;
    check("async_adr", bus.O_adr, 32'h0);
    check("async_instr", bus.O_instr, 32'h0000_0013);
    check("async_stb", {31'b0, bus.O_stb}, 32'h0);
    model_reset();
    @(negedge clk); @(negedge clk);
    bus.I_stall = 1'b0; bus.I_stall_instr = 1'b0; bus.I_pc_src = 1'b0;
    rst_n = 1'b1;
    run(3);
    check("post_reset_adr", bus.O_adr, 32'hC);
    check("post_reset_instr", bus.O_instr, 32'hE000_0004);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
